// File: rtl/arb_pkg.sv
// Shared types and defaults for the feature-RAM read arbiter.
package arb_pkg;

  localparam int unsigned RAM_LANES  = 9;
  localparam int unsigned RAM_ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } arbState_t;

  // Ceiling log2, never less than 1 so it can size an index or counter port.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    int unsigned rem;
    width = 0;
    rem   = (value > 0) ? value - 1 : 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (rem != 0) begin
        width = width + 1;
        rem   = rem >> 1;
      end
    end
    return (width == 0) ? 1 : width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above rrPtr, wrapping modulo NUM_REQ.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rrPtr,
  output logic               grantValid,
  output logic [IDX_W-1:0]   grantIdx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(rrPtr) + i) % NUM_REQ);
      if (!grantValid && req[cand]) begin
        grantValid = 1'b1;
        grantIdx   = cand;
      end
    end
  end

endmodule

// File: rtl/ram_read_arbiter.sv
// Shares the 9-lane feature-RAM read port among NUM_REQ layer controllers,
// granting round-robin and returning a one-cycle valid pulse to the owner.
module ram_read_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned LANES   = RAM_LANES,
  parameter int unsigned ADDR_W  = RAM_ADDR_W,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic [NUM_REQ-1:0]                 i_req_start,
  input  logic [NUM_REQ*LANES*ADDR_W-1:0]    i_req_addr,
  input  logic [NUM_REQ-1:0]                 i_req_mask,
  output logic [NUM_REQ-1:0]                 o_req_valid,
  output logic                               o_ram_start,
  output logic [LANES*ADDR_W-1:0]            o_ram_addr,
  output logic                               o_ram_mask,
  input  logic                               i_ram_valid,
  output logic                               o_busy,
  output logic [clog2(NUM_REQ)-1:0]          o_owner,
  output logic                               o_overrun,
  output logic                               o_timeout
);

  localparam int unsigned IDX_W    = clog2(NUM_REQ);
  localparam int unsigned CNT_W    = clog2(TIMEOUT + 1);
  localparam int unsigned BUNDLE_W = LANES * ADDR_W;

  arbState_t            state, stateNext;
  logic [NUM_REQ-1:0]   pending, pendingNext;
  logic [IDX_W-1:0]     rrPtr, rrPtrNext;
  logic [IDX_W-1:0]     owner, ownerNext;
  logic [CNT_W-1:0]     waitCnt, waitCntNext;
  logic                 overrun, overrunNext;
  logic                 timeout, timeoutNext;

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   ownerMask;
  logic [NUM_REQ-1:0]   busyOwnerMask;
  logic [NUM_REQ-1:0]   collide;
  logic [NUM_REQ-1:0]   accepted;
  logic                 grantValid;
  logic [IDX_W-1:0]     grantIdx;
  logic [BUNDLE_W-1:0]  addrSel;
  logic                 maskSel;
  logic                 busy;

  assign busy = (state != IDLE);

  always_comb begin
    ownerMask        = '0;
    ownerMask[owner] = 1'b1;
  end

  // A start from a requester that is already queued or holding the port is dropped.
  assign busyOwnerMask = busy ? ownerMask : '0;
  assign collide       = i_req_start & (pending | busyOwnerMask);
  assign accepted      = i_req_start & ~collide;
  assign req           = pending | i_req_start;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req),
    .rrPtr      (rrPtr),
    .grantValid (grantValid),
    .grantIdx   (grantIdx)
  );

  always_comb begin
    stateNext   = state;
    pendingNext = pending | accepted;
    rrPtrNext   = rrPtr;
    ownerNext   = owner;
    waitCntNext = waitCnt;
    overrunNext = overrun | (|collide);
    timeoutNext = timeout;
    case (state)
      IDLE: begin
        if (grantValid) begin
          ownerNext             = grantIdx;
          pendingNext[grantIdx] = 1'b0;
          if (32'(grantIdx) == NUM_REQ - 1) rrPtrNext = '0;
          else                              rrPtrNext = grantIdx + 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        waitCntNext = '0;
        stateNext   = WAIT;
      end
      WAIT: begin
        waitCntNext = waitCnt + 1'b1;
        // A completion arriving in the same cycle as the limit takes priority.
        if (i_ram_valid) begin
          stateNext = RELEASE;
        end else if ((TIMEOUT != 0) && ((32'(waitCnt) + 1) == TIMEOUT)) begin
          timeoutNext = 1'b1;
          stateNext   = IDLE;
        end
      end
      RELEASE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= IDLE;
      pending <= '0;
      rrPtr   <= '0;
      owner   <= '0;
      waitCnt <= '0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= stateNext;
      pending <= pendingNext;
      rrPtr   <= rrPtrNext;
      owner   <= ownerNext;
      waitCnt <= waitCntNext;
      overrun <= overrunNext;
      timeout <= timeoutNext;
    end
  end

  always_comb begin
    addrSel = '0;
    maskSel = 1'b0;
    for (int unsigned n = 0; n < NUM_REQ; n++) begin
      if (32'(owner) == n) begin
        addrSel = i_req_addr[n*BUNDLE_W +: BUNDLE_W];
        maskSel = i_req_mask[n];
      end
    end
  end

  assign o_busy      = busy;
  assign o_ram_start = (state == ISSUE);
  assign o_req_valid = (state == RELEASE) ? ownerMask : '0;
  assign o_ram_addr  = busy ? addrSel : '0;
  assign o_ram_mask  = busy & maskSel;
  assign o_owner     = owner;
  assign o_overrun   = overrun;
  assign o_timeout   = timeout;

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Bench for ram_read_arbiter: vector table of start patterns plus hand-written
// latency, overrun, timeout, reset and stray-valid sequences.
module tb_ram_read_arbiter;

  localparam int unsigned NR  = 3;
  localparam int unsigned LN  = 9;
  localparam int unsigned AW  = 12;
  localparam int unsigned TMO = 16;

  logic                 i_clk;
  logic                 i_reset;
  logic [NR-1:0]        i_req_start;
  logic [NR*LN*AW-1:0]  i_req_addr;
  logic [NR-1:0]        i_req_mask;
  logic [NR-1:0]        o_req_valid;
  logic                 o_ram_start;
  logic [LN*AW-1:0]     o_ram_addr;
  logic                 o_ram_mask;
  logic                 i_ram_valid;
  logic                 o_busy;
  logic [1:0]           o_owner;
  logic                 o_overrun;
  logic                 o_timeout;

  ram_read_arbiter #(
    .NUM_REQ (NR),
    .LANES   (LN),
    .ADDR_W  (AW),
    .TIMEOUT (TMO)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_start (i_req_start),
    .i_req_addr  (i_req_addr),
    .i_req_mask  (i_req_mask),
    .o_req_valid (o_req_valid),
    .o_ram_start (o_ram_start),
    .o_ram_addr  (o_ram_addr),
    .o_ram_mask  (o_ram_mask),
    .i_ram_valid (i_ram_valid),
    .o_busy      (o_busy),
    .o_owner     (o_owner),
    .o_overrun   (o_overrun),
    .o_timeout   (o_timeout)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic [2:0]  start;
    int unsigned lat;
    int unsigned nGrant;
    logic [5:0]  order;
  } vec_t;

  int          nCmp = 0;
  int          nFail = 0;
  int unsigned grantQ[$];
  logic [2:0]  validQ[$];
  int unsigned ramLat = 1;
  bit          ramEnable = 1'b1;
  int unsigned pokeCount = 0;
  int unsigned pokeSeen = 0;
  vec_t        vecs[8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LN*AW-1:0] expAddr(input int unsigned n);
    logic [LN*AW-1:0] a;
    for (int unsigned l = 0; l < LN; l++) a[l*AW +: AW] = 12'(256 * (n + 1) + l);
    return a;
  endfunction

  // Requester masks are fixed at 3'b101.
  function automatic logic expMask(input int unsigned n);
    return (n != 1);
  endfunction

  function automatic vec_t mk(input logic [2:0] s, input int unsigned lat, input int unsigned n,
                              input logic [1:0] g0, input logic [1:0] g1, input logic [1:0] g2);
    vec_t v;
    v.start  = s;
    v.lat    = lat;
    v.nGrant = n;
    v.order  = {g2, g1, g0};
    return v;
  endfunction

  // RAM model: answers each o_ram_start after ramLat cycles, or emits a stray pulse on request.
  initial begin
    i_ram_valid = 1'b0;
    forever begin
      @(negedge i_clk);
      if (pokeCount != pokeSeen) begin
        pokeSeen = pokeCount;
        i_ram_valid = 1'b1;
        @(negedge i_clk);
        i_ram_valid = 1'b0;
      end else if (o_ram_start === 1'b1 && ramEnable) begin
        repeat (ramLat) @(negedge i_clk);
        i_ram_valid = 1'b1;
        @(negedge i_clk);
        i_ram_valid = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    int unsigned eg;
    logic [2:0]  ev;
    forever begin
      @(negedge i_clk);
      if (o_ram_start === 1'b1) begin
        if (grantQ.size() == 0) begin
          nCmp++;
          nFail++;
          $display("FAIL unexpected_grant: got owner %0d expected no grant", o_owner);
        end else begin
          eg = grantQ.pop_front();
          chk("grant_owner", 128'(o_owner), 128'(eg));
          chk("grant_addr", 128'(o_ram_addr), 128'(expAddr(eg)));
          chk("grant_mask", 128'(o_ram_mask), 128'(expMask(eg)));
        end
      end
      if (o_req_valid !== 3'b000) begin
        if (validQ.size() == 0) begin
          nCmp++;
          nFail++;
          $display("FAIL unexpected_valid: got %b expected none", o_req_valid);
        end else begin
          ev = validQ.pop_front();
          chk("req_valid", 128'(o_req_valid), 128'(ev));
        end
      end
    end
  end

  task automatic waitIdle(input int maxCyc);
    int n;
    n = 0;
    repeat (2) @(negedge i_clk);
    while (o_busy || grantQ.size() != 0 || validQ.size() != 0) begin
      if (n >= maxCyc) begin
        nCmp++;
        nFail++;
        $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
        grantQ.delete();
        validQ.delete();
        break;
      end
      @(negedge i_clk);
      n++;
    end
  endtask

  task automatic expectGrant(input int unsigned n, input bit withValid);
    grantQ.push_back(n);
    if (withValid) validQ.push_back(3'(1 << n));
  endtask

  initial begin
    int unsigned g;
    bit anyBusy;
    bit anyValid;

    i_reset     = 1'b0;
    i_req_start = '0;
    i_req_mask  = 3'b101;
    for (int unsigned n = 0; n < NR; n++)
      for (int unsigned l = 0; l < LN; l++)
        i_req_addr[(n*LN + l)*AW +: AW] = 12'(256 * (n + 1) + l);

    vecs[0] = mk(3'b100, 1, 1, 2'd2, 2'd0, 2'd0);
    vecs[1] = mk(3'b111, 1, 3, 2'd0, 2'd1, 2'd2);
    vecs[2] = mk(3'b111, 3, 3, 2'd0, 2'd1, 2'd2);
    vecs[3] = mk(3'b110, 2, 2, 2'd1, 2'd2, 2'd0);
    vecs[4] = mk(3'b011, 1, 2, 2'd0, 2'd1, 2'd0);
    vecs[5] = mk(3'b101, 4, 2, 2'd2, 2'd0, 2'd0);
    vecs[6] = mk(3'b001, 1, 1, 2'd0, 2'd0, 2'd0);
    vecs[7] = mk(3'b010, 2, 1, 2'd1, 2'd0, 2'd0);

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_start", 128'(o_ram_start), 128'(0));
    chk("rst_valid", 128'(o_req_valid), 128'(0));
    chk("rst_addr", 128'(o_ram_addr), 128'(0));
    chk("rst_owner", 128'(o_owner), 128'(0));
    chk("rst_flags", 128'({o_overrun, o_timeout, o_ram_mask}), 128'(0));
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);

    // Single request latency
    ramLat = 1;
    i_req_start = 3'b001;
    expectGrant(0, 1'b1);
    @(negedge i_clk);
    i_req_start = '0;
    chk("t1_start_t1", 128'(o_ram_start), 128'(1));
    chk("t1_addr", 128'(o_ram_addr), 128'(expAddr(0)));
    @(negedge i_clk);
    chk("t1_start_once", 128'(o_ram_start), 128'(0));
    chk("t1_busy_wait", 128'(o_busy), 128'(1));
    @(negedge i_clk);
    chk("t1_valid", 128'(o_req_valid), 128'(3'b001));
    @(negedge i_clk);
    chk("t1_idle", 128'(o_busy), 128'(0));
    waitIdle(50);

    // Vector table: start patterns with hand-derived round-robin order
    foreach (vecs[i]) begin
      ramLat = vecs[i].lat;
      i_req_start = vecs[i].start;
      for (int unsigned k = 0; k < vecs[i].nGrant; k++) begin
        g = 32'(vecs[i].order[2*k +: 2]);
        expectGrant(g, 1'b1);
      end
      @(negedge i_clk);
      i_req_start = '0;
      waitIdle(200);
    end

    // Overrun: second start[1] while 1 is pending
    ramLat = 4;
    i_req_start = 3'b001;
    expectGrant(0, 1'b1);
    expectGrant(1, 1'b1);
    @(negedge i_clk);
    i_req_start = '0;
    @(negedge i_clk);
    i_req_start = 3'b010;
    @(negedge i_clk);
    i_req_start = '0;
    chk("ovr_clear", 128'(o_overrun), 128'(0));
    @(negedge i_clk);
    i_req_start = 3'b010;
    @(negedge i_clk);
    i_req_start = '0;
    chk("ovr_set", 128'(o_overrun), 128'(1));
    waitIdle(200);
    chk("ovr_sticky", 128'(o_overrun), 128'(1));

    // Valid arriving on the last allowed WAIT cycle wins over the timeout
    ramLat = TMO;
    i_req_start = 3'b100;
    expectGrant(2, 1'b1);
    @(negedge i_clk);
    i_req_start = '0;
    waitIdle(200);
    chk("tmo_valid_wins", 128'(o_timeout), 128'(0));

    // RAM never answers: timeout after 16 WAIT cycles, pending 2 granted next
    ramEnable = 1'b0;
    ramLat = 1;
    i_req_start = 3'b001;
    expectGrant(0, 1'b0);
    expectGrant(2, 1'b1);
    @(negedge i_clk);
    i_req_start = '0;
    @(negedge i_clk);
    i_req_start = 3'b100;
    @(negedge i_clk);
    i_req_start = '0;
    repeat (14) @(negedge i_clk);
    chk("tmo_not_yet", 128'({o_timeout, o_busy}), 128'(2'b01));
    @(negedge i_clk);
    chk("tmo_set", 128'({o_timeout, o_busy}), 128'(2'b10));
    chk("tmo_no_valid", 128'(o_req_valid), 128'(0));
    ramEnable = 1'b1;
    waitIdle(200);
    chk("tmo_sticky", 128'(o_timeout), 128'(1));

    // Reset during WAIT aborts and drops pending requests
    ramEnable = 1'b0;
    i_req_start = 3'b001;
    expectGrant(0, 1'b0);
    @(negedge i_clk);
    i_req_start = '0;
    @(negedge i_clk);
    i_req_start = 3'b110;
    @(negedge i_clk);
    i_req_start = '0;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    chk("mrst_busy", 128'(o_busy), 128'(0));
    chk("mrst_addr", 128'(o_ram_addr), 128'(0));
    chk("mrst_outs", 128'({o_ram_start, o_req_valid, o_ram_mask, o_owner}), 128'(0));
    chk("mrst_flags", 128'({o_overrun, o_timeout}), 128'(0));
    @(negedge i_clk);
    i_reset = 1'b1;
    ramEnable = 1'b1;
    anyBusy = 1'b0;
    repeat (8) begin
      @(negedge i_clk);
      if (o_busy) anyBusy = 1'b1;
    end
    chk("mrst_no_grant", 128'(anyBusy), 128'(0));

    // Stray i_ram_valid while IDLE
    pokeCount = pokeCount + 1;
    anyBusy = 1'b0;
    anyValid = 1'b0;
    repeat (5) begin
      @(negedge i_clk);
      if (o_busy) anyBusy = 1'b1;
      if (o_req_valid != 3'b000) anyValid = 1'b1;
    end
    chk("stray_valid", 128'(anyValid), 128'(0));
    chk("stray_state", 128'(anyBusy), 128'(0));

    chk("grantq_empty", 128'(grantQ.size()), 128'(0));
    chk("validq_empty", 128'(validQ.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
